// File: rtl/adc_spi_capture.sv
// adc_spi_capture
//   Periodic SPI ADC sampler feeding a 16-bit synchronous FIFO. Each sample
//   period it pulses CNV, clocks 16 bits out of the ADC (MSB first) and
//   pushes the assembled word into the FIFO. A write is suppressed while the
//   FIFO reports full, and the lost sample is recorded in a sticky flag.
//
// Parameters
//   CONV_CYCLES    clk cycles adc_cnv is held high per conversion (>=1)
//   CLK_DIV        clk cycles per SCLK half-period (>=1)
//   SAMPLE_PERIOD  clk cycles between conversion starts
//                  (>= CONV_CYCLES + 32*CLK_DIV + 2)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   enable       level, 1 = run periodic sampling
//   adc_cnv      ADC convert-start, high during CONVERT
//   adc_sclk     ADC serial clock, idles low
//   adc_sdo      ADC serial data, sampled on the clk edge raising adc_sclk
//   fifo_full    FIFO full flag
//   fifo_wr_en   one-cycle FIFO write strobe
//   fifo_data    sample to FIFO, valid with fifo_wr_en; holds last push
//   overrun      sticky, set when a sample is dropped on fifo_full
//   overrun_clr  clears overrun (a same-cycle set wins)
//   busy         high in any state except IDLE
module adc_spi_capture #(
  parameter int unsigned CONV_CYCLES   = 20,
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        adc_cnv,
  output logic        adc_sclk,
  input  logic        adc_sdo,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [15:0] fifo_data,
  output logic        overrun,
  input  logic        overrun_clr,
  output logic        busy
);

  localparam int unsigned PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned CW = (CONV_CYCLES   > 1) ? $clog2(CONV_CYCLES)   : 1;
  localparam int unsigned DW = (CLK_DIV       > 1) ? $clog2(CLK_DIV)       : 1;

  localparam logic [PW-1:0] P_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CONV_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CONVERT = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_PUSH    = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [PW-1:0] pcnt;
  logic [CW-1:0] ccnt;
  logic [DW-1:0] dcnt;
  logic [4:0]    hcnt;
  logic [15:0]   shreg;
  logic          half_done;
  logic          start;

  // End of the current SCLK half-period.
  assign half_done = (dcnt == D_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (enable) state_nxt = S_CONVERT;
      S_CONVERT: if (ccnt == C_LAST) state_nxt = S_SHIFT;
      // hcnt counts completed half-periods; 31 is the 16th high phase.
      S_SHIFT:   if (half_done && (hcnt == 5'd31)) state_nxt = S_PUSH;
      S_PUSH:    state_nxt = S_WAIT;
      S_WAIT:    if (pcnt == P_LAST) state_nxt = enable ? S_CONVERT : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  assign start = (state_nxt == S_CONVERT) && (state != S_CONVERT);

  // Outputs are registered from the next-state value so that adc_cnv and
  // busy line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      adc_cnv    <= 1'b0;
      adc_sclk   <= 1'b0;
      fifo_wr_en <= 1'b0;
      fifo_data  <= '0;
      overrun    <= 1'b0;
      pcnt       <= '0;
      ccnt       <= '0;
      dcnt       <= '0;
      hcnt       <= '0;
      shreg      <= '0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt != S_IDLE);
      adc_cnv    <= (state_nxt == S_CONVERT);
      fifo_wr_en <= 1'b0;

      if (start)
        pcnt <= '0;
      else if (state != S_IDLE)
        pcnt <= pcnt + 1'b1;

      if (start)
        ccnt <= '0;
      else if (state == S_CONVERT)
        ccnt <= ccnt + 1'b1;

      if (state == S_SHIFT) begin
        if (half_done) begin
          dcnt     <= '0;
          hcnt     <= hcnt + 1'b1;
          adc_sclk <= ~adc_sclk;
          // Capture on the edge that raises SCLK; SDO was set up after the
          // previous falling edge.
          if (!adc_sclk)
            shreg <= {shreg[14:0], adc_sdo};
        end else begin
          dcnt <= dcnt + 1'b1;
        end
      end else begin
        dcnt     <= '0;
        hcnt     <= '0;
        adc_sclk <= 1'b0;
      end

      if ((state == S_PUSH) && !fifo_full) begin
        fifo_wr_en <= 1'b1;
        fifo_data  <= shreg;
      end

      if ((state == S_PUSH) && fifo_full)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_spi_capture.sv
module tb_adc_spi_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        adc_cnv;
  logic        adc_sclk;
  logic        adc_sdo = 1'b0;
  logic        fifo_full = 1'b0;
  logic        fifo_wr_en;
  logic [15:0] fifo_data;
  logic        overrun;
  logic        overrun_clr = 1'b0;
  logic        busy;

  logic        f_enable = 1'b0;
  logic        f_cnv;
  logic        f_sclk;
  logic        f_sdo = 1'b0;
  logic        f_full = 1'b0;
  logic        f_wr;
  logic [15:0] f_data;
  logic        f_ovr;
  logic        f_clr = 1'b0;
  logic        f_busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_spi_capture u_dut (
    .clk(clk), .rst(rst), .enable(enable), .adc_cnv(adc_cnv), .adc_sclk(adc_sclk),
    .adc_sdo(adc_sdo), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_data(fifo_data), .overrun(overrun), .overrun_clr(overrun_clr), .busy(busy)
  );

  adc_spi_capture #(.CONV_CYCLES(1), .CLK_DIV(1), .SAMPLE_PERIOD(35)) u_fast (
    .clk(clk), .rst(rst), .enable(f_enable), .adc_cnv(f_cnv), .adc_sclk(f_sclk),
    .adc_sdo(f_sdo), .fifo_full(f_full), .fifo_wr_en(f_wr),
    .fifo_data(f_data), .overrun(f_ovr), .overrun_clr(f_clr), .busy(f_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-sample vectors: ADC word, FIFO full during PUSH, overrun_clr during
  // PUSH, overrun_clr after PUSH, expected overrun right after PUSH.
  typedef struct {
    logic [15:0] data;
    logic        full;
    logic        clr_in_push;
    logic        clr_after;
    logic        exp_ovr;
  } vec_t;
  localparam int NV = 8;
  vec_t vecs[NV];

  logic [15:0] exp_q[$];
  logic [15:0] f_q[$];

  // ADC model, default instance: word loaded when CNV falls, next bit after
  // each SCLK falling edge.
  int          m_idx = 0;
  logic [15:0] m_sr = '0;
  logic [15:0] m_data;
  always @(negedge adc_cnv) begin
    if (!rst) begin
      if (m_idx < NV) begin
        m_data    = vecs[m_idx].data;
        fifo_full = vecs[m_idx].full;
      end else begin
        m_data    = {8'hC0, 8'(m_idx)};
        fifo_full = 1'b0;
      end
      if (!fifo_full) exp_q.push_back(m_data);
      m_sr    = m_data;
      adc_sdo = m_sr[15];
      m_idx++;
    end
  end
  always @(negedge adc_sclk) begin
    if (!rst) begin
      m_sr    = {m_sr[14:0], 1'b0};
      adc_sdo = m_sr[15];
    end
  end

  // ADC model, fast instance.
  logic [15:0] fw[6];
  int          f_idx = 0;
  logic [15:0] f_sr = '0;
  logic [15:0] f_word;
  always @(negedge f_cnv) begin
    if (!rst) begin
      f_word = (f_idx < 6) ? fw[f_idx] : {8'hD0, 8'(f_idx)};
      f_q.push_back(f_word);
      f_sr  = f_word;
      f_sdo = f_sr[15];
      f_idx++;
    end
  end
  always @(negedge f_sclk) begin
    if (!rst) begin
      f_sr  = {f_sr[14:0], 1'b0};
      f_sdo = f_sr[15];
    end
  end

  // Scoreboard monitors.
  logic cnv_prev = 1'b0;
  int   cnv_rise_cyc = 0;
  int   cnv_rises = 0;
  int   wr_count = 0;
  always @(negedge clk) begin
    if (adc_cnv && !cnv_prev) begin
      cnv_rise_cyc = cyc;
      cnv_rises++;
    end
    cnv_prev = adc_cnv;
    if (adc_cnv && adc_sclk) check("cnv_sclk_overlap", 1, 0);
    if (fifo_wr_en) begin
      wr_count++;
      if (exp_q.size() == 0) check("unexpected_write", {16'h0, fifo_data}, 32'hFFFF_FFFF);
      else check("wr_data", fifo_data, exp_q.pop_front());
      check("wr_latency", cyc - cnv_rise_cyc, 149);
    end
  end

  logic f_prev = 1'b0;
  int   f_rise = 0;
  int   f_last_wr = -1;
  int   f_wr_count = 0;
  always @(negedge clk) begin
    if (f_cnv && !f_prev) f_rise = cyc;
    f_prev = f_cnv;
    if (f_wr) begin
      f_wr_count++;
      if (f_q.size() == 0) check("fast_unexpected_write", {16'h0, f_data}, 32'hFFFF_FFFF);
      else check("fast_wr_data", f_data, f_q.pop_front());
      check("fast_latency", cyc - f_rise, 34);
      if (f_last_wr >= 0) check("fast_interval", cyc - f_last_wr, 35);
      f_last_wr = cyc;
    end
  end

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_cnv_rise(output int t);
    logic prev;
    int   n;
    prev = adc_cnv;
    t = -1;
    n = 0;
    while (n < 1000) begin
      @(negedge clk);
      n++;
      if (adc_cnv && !prev) begin
        t = cyc;
        break;
      end
      prev = adc_cnv;
    end
    if (t < 0) begin
      check("cnv_rise_timeout", 0, 1);
      t = cyc;
    end
  endtask

  task automatic wait_sclk_rises(input int count);
    logic prev;
    int   seen;
    int   n;
    prev = adc_sclk;
    seen = 0;
    n = 0;
    while (seen < count && n < 2000) begin
      @(negedge clk);
      n++;
      if (adc_sclk && !prev) seen++;
      prev = adc_sclk;
    end
    if (seen < count) check("sclk_rise_timeout", seen, count);
  endtask

  initial begin
    int t0, tp, t1, w, r, n;

    vecs[0] = '{16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h8001, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{16'h7FFE, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'h1234, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{16'h4321, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{16'h0F0F, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    fw[0] = 16'h8001; fw[1] = 16'h7FFE; fw[2] = 16'hA5C3;
    fw[3] = 16'h0001; fw[4] = 16'hFFFE; fw[5] = 16'h5AA5;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_cnv", adc_cnv, 0);
    check("rst_sclk", adc_sclk, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_data", fifo_data, 16'h0000);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);

    // Periodic sampling through the vector table
    enable = 1'b1;
    tp = 0;
    for (int i = 0; i < NV; i++) begin
      wait_cnv_rise(t0);
      if (i > 0) check("period", t0 - tp, 200);
      tp = t0;
      wait_until(t0 + 148);
      overrun_clr = vecs[i].clr_in_push;
      wait_until(t0 + 149);
      overrun_clr = 1'b0;
      check("overrun_after_push", overrun, vecs[i].exp_ovr);
      check("wr_en_after_push", fifo_wr_en, !vecs[i].full);
      check("busy_in_wait", busy, 1);
      if (vecs[i].clr_after) begin
        wait_until(t0 + 150);
        overrun_clr = 1'b1;
        wait_until(t0 + 151);
        overrun_clr = 1'b0;
        check("overrun_cleared", overrun, 0);
      end
    end

    // enable dropped mid-shift and re-asserted during WAIT: no gap
    wait_cnv_rise(t0);
    check("period", t0 - tp, 200);
    wait_sclk_rises(10);
    enable = 1'b0;
    wait_until(t0 + 170);
    enable = 1'b1;
    wait_cnv_rise(t1);
    check("no_gap_reenable", t1 - t0, 200);

    // enable dropped at 10th SCLK rise: sample completes, then idle
    wait_sclk_rises(10);
    enable = 1'b0;
    w = wr_count;
    wait_until(t1 + 150);
    check("push_after_disable", wr_count - w, 1);
    wait_until(t1 + 199);
    check("busy_end_wait", busy, 1);
    wait_until(t1 + 200);
    check("busy_idle", busy, 0);
    r = cnv_rises;
    wait_until(t1 + 500);
    check("no_cnv_after_disable", cnv_rises - r, 0);
    check("still_idle", busy, 0);

    // Reset mid-SHIFT
    enable = 1'b1;
    wait_cnv_rise(t0);
    wait_until(t0 + 60);
    check("mid_shift_busy", busy, 1);
    exp_q.delete();
    w = wr_count;
    rst = 1'b1;
    wait_until(t0 + 61);
    rst = 1'b0;
    check("rst_mid_sclk", adc_sclk, 0);
    check("rst_mid_cnv", adc_cnv, 0);
    check("rst_mid_wr_en", fifo_wr_en, 0);
    check("rst_mid_busy", busy, 0);
    wait_until(t0 + 62);
    check("restart_cnv", adc_cnv, 1);
    wait_until(t0 + 62 + 148);
    check("no_partial_push", wr_count - w, 0);
    wait_until(t0 + 62 + 150);
    check("fresh_push", wr_count - w, 1);
    enable = 1'b0;
    wait_until(t0 + 62 + 260);
    check("idle_after_restart", busy, 0);

    // Fast configuration: back-to-back samples
    f_enable = 1'b1;
    n = 0;
    while (f_wr_count < 6 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    f_enable = 1'b0;
    check("fast_sample_count", (f_wr_count >= 6), 1);
    repeat (100) @(negedge clk);
    check("fast_idle", f_busy, 0);

    check("scoreboard_drain", exp_q.size(), 0);
    check("fast_scoreboard_drain", f_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
